// File: rtl/bp_cce_gpr_wr_sched_if.sv
// rtl/bp_cce_gpr_wr_sched_if.sv - request/grant bus of the CCE GPR write-port scheduler
interface bp_cce_gpr_wr_sched_if #(
    parameter int num_gpr_p   = 8,
    parameter int gpr_width_p = 64
);
    localparam int gpr_sel_width_lp = $clog2(num_gpr_p);

    logic                        inst_v_i;
    logic                        inst_w_v_i;
    logic [gpr_sel_width_lp-1:0] inst_dst_i;
    logic [num_gpr_p-1:0]        inst_src_mask_i;
    logic [gpr_width_p-1:0]      inst_data_i;
    logic                        stall_o;

    logic                        dir_v_i;
    logic [gpr_sel_width_lp-1:0] dir_dst_i;
    logic [gpr_width_p-1:0]      dir_data_i;
    logic                        dir_ready_o;

    logic                        cfg_v_i;
    logic [gpr_sel_width_lp-1:0] cfg_dst_i;
    logic [gpr_width_p-1:0]      cfg_data_i;
    logic                        cfg_ready_o;

    logic                        gpr_w_v_o;
    logic [gpr_sel_width_lp-1:0] gpr_w_sel_o;
    logic [gpr_width_p-1:0]      gpr_w_data_o;
    logic [num_gpr_p-1:0]        pending_o;

    modport slave (
        input  inst_v_i, inst_w_v_i, inst_dst_i, inst_src_mask_i, inst_data_i,
        input  dir_v_i, dir_dst_i, dir_data_i,
        input  cfg_v_i, cfg_dst_i, cfg_data_i,
        output stall_o, dir_ready_o, cfg_ready_o,
        output gpr_w_v_o, gpr_w_sel_o, gpr_w_data_o, pending_o
    );

    modport master (
        output inst_v_i, inst_w_v_i, inst_dst_i, inst_src_mask_i, inst_data_i,
        output dir_v_i, dir_dst_i, dir_data_i,
        output cfg_v_i, cfg_dst_i, cfg_data_i,
        input  stall_o, dir_ready_o, cfg_ready_o,
        input  gpr_w_v_o, gpr_w_sel_o, gpr_w_data_o, pending_o
    );
endinterface

// File: rtl/bp_cce_gpr_wr_sched.sv
// rtl/bp_cce_gpr_wr_sched.sv - GPR write-port scheduler with directory FIFO and pending-write scoreboard
// Optional same-cycle directory bypass: BP_CCE_GPR_WR_SCHED_BYPASS_EN
module bp_cce_gpr_wr_sched #(
    parameter int num_gpr_p      = 8,
    parameter int gpr_width_p    = 64,
    parameter int dir_fifo_els_p = 2,
    parameter int starve_limit_p = 4
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bp_cce_gpr_wr_sched_if.slave   bus
);
    localparam int gpr_sel_width_lp = $clog2(num_gpr_p);
    localparam int cnt_width_lp     = $clog2(dir_fifo_els_p + 1);
    localparam int ptr_width_lp     = $clog2(dir_fifo_els_p);
    localparam int starve_width_lp  = $clog2(starve_limit_p + 1);

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_FIFO,
        GNT_DIR,
        GNT_INST,
        GNT_CFG
    } gnt_e;

    logic [gpr_sel_width_lp-1:0] fifo_dst_q  [dir_fifo_els_p];
    logic [gpr_width_p-1:0]      fifo_data_q [dir_fifo_els_p];
    logic [ptr_width_lp-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_width_lp-1:0]     fill_q, fill_d;
    logic [cnt_width_lp-1:0]     cnt_q [num_gpr_p];
    logic [cnt_width_lp-1:0]     cnt_d [num_gpr_p];
    logic [starve_width_lp-1:0]  starve_q, starve_d;

    logic [num_gpr_p-1:0]        pend;
    logic                        full, empty, hazard, starve_ovr, enq, deq;
    logic [gpr_sel_width_lp-1:0] head_dst;
    gnt_e                        gnt;

    always_comb begin
        pend = '0;
        for (int i = 0; i < num_gpr_p; i++) begin
            pend[i] = (cnt_q[i] != '0);
        end
    end

    assign full       = (fill_q == cnt_width_lp'(dir_fifo_els_p));
    assign empty      = (fill_q == '0);
    assign head_dst   = fifo_dst_q[rptr_q];
    assign hazard     = (|(bus.inst_src_mask_i & pend)) | (bus.inst_w_v_i & pend[bus.inst_dst_i]);
    assign starve_ovr = bus.cfg_v_i & (starve_q == starve_width_lp'(starve_limit_p));

    // Fixed-priority arbitration; nothing is granted while reset is held.
    always_comb begin
        gnt = GNT_NONE;
        if (reset_i) begin
            gnt = GNT_NONE;
        end else if (starve_ovr) begin
            gnt = GNT_CFG;
        end else if (!empty) begin
            gnt = GNT_FIFO;
`ifdef BP_CCE_GPR_WR_SCHED_BYPASS_EN
        end else if (bus.dir_v_i) begin
            gnt = GNT_DIR;
`endif
        end else if (bus.inst_v_i && bus.inst_w_v_i && !hazard) begin
            gnt = GNT_INST;
        end else if (bus.cfg_v_i) begin
            gnt = GNT_CFG;
        end
    end

    always_comb begin
        bus.gpr_w_v_o    = 1'b0;
        bus.gpr_w_sel_o  = '0;
        bus.gpr_w_data_o = '0;
        case (gnt)
            GNT_FIFO: begin
                bus.gpr_w_v_o    = 1'b1;
                bus.gpr_w_sel_o  = head_dst;
                bus.gpr_w_data_o = fifo_data_q[rptr_q];
            end
            GNT_DIR: begin
                bus.gpr_w_v_o    = 1'b1;
                bus.gpr_w_sel_o  = bus.dir_dst_i;
                bus.gpr_w_data_o = bus.dir_data_i;
            end
            GNT_INST: begin
                bus.gpr_w_v_o    = 1'b1;
                bus.gpr_w_sel_o  = bus.inst_dst_i;
                bus.gpr_w_data_o = bus.inst_data_i;
            end
            GNT_CFG: begin
                bus.gpr_w_v_o    = 1'b1;
                bus.gpr_w_sel_o  = bus.cfg_dst_i;
                bus.gpr_w_data_o = bus.cfg_data_i;
            end
            default: begin
                bus.gpr_w_v_o    = 1'b0;
            end
        endcase
    end

    assign bus.stall_o     = ~reset_i & bus.inst_v_i & (hazard | (bus.inst_w_v_i & (gnt != GNT_INST)));
    assign bus.cfg_ready_o = (gnt == GNT_CFG);
    assign bus.dir_ready_o = ~full;
    assign bus.pending_o   = reset_i ? '0 : pend;

    // A bypassed directory write never occupies a FIFO slot or a scoreboard count.
    assign enq = bus.dir_v_i & ~full & ~reset_i & (gnt != GNT_DIR);
    assign deq = (gnt == GNT_FIFO);

    always_comb begin
        wptr_d = enq ? wptr_q + ptr_width_lp'(1) : wptr_q;
        rptr_d = deq ? rptr_q + ptr_width_lp'(1) : rptr_q;
        fill_d = fill_q;
        if (enq && !deq) fill_d = fill_q + cnt_width_lp'(1);
        if (!enq && deq) fill_d = fill_q - cnt_width_lp'(1);
        for (int i = 0; i < num_gpr_p; i++) begin
            cnt_d[i] = cnt_q[i];
            if (enq && bus.dir_dst_i == gpr_sel_width_lp'(i)) cnt_d[i] = cnt_d[i] + cnt_width_lp'(1);
            if (deq && head_dst == gpr_sel_width_lp'(i))      cnt_d[i] = cnt_d[i] - cnt_width_lp'(1);
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.cfg_v_i || gnt == GNT_CFG) begin
            starve_d = '0;
        end else if (starve_q != starve_width_lp'(starve_limit_p)) begin
            starve_d = starve_q + starve_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            fill_q   <= '0;
            starve_q <= '0;
            for (int i = 0; i < num_gpr_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fill_q   <= fill_d;
            starve_q <= starve_d;
            for (int i = 0; i < num_gpr_p; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Entry storage needs no reset: stale slots are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_dst_q[wptr_q]  <= bus.dir_dst_i;
            fifo_data_q[wptr_q] <= bus.dir_data_i;
        end
    end
endmodule

// File: tb/tb_bp_cce_gpr_wr_sched.sv
// tb/tb_bp_cce_gpr_wr_sched.sv - directed vector bench for bp_cce_gpr_wr_sched
module tb_bp_cce_gpr_wr_sched;
    localparam int NG = 8;
    localparam int GW = 64;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    bit   started = 0;

    always #5 clk = ~clk;

    bp_cce_gpr_wr_sched_if #(.num_gpr_p(NG), .gpr_width_p(GW)) bus ();

    bp_cce_gpr_wr_sched #(
        .num_gpr_p(NG), .gpr_width_p(GW), .dir_fifo_els_p(DEPTH), .starve_limit_p(4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    typedef struct {
        logic        rst;
        logic        iv, iw;
        logic [2:0]  idst;
        logic [7:0]  isrc;
        logic [63:0] idata;
        logic        dv;
        logic [2:0]  ddst;
        logic [63:0] ddata;
        logic        cv;
        logic [2:0]  cdst;
        logic [63:0] cdata;
        logic        e_stall, e_dready, e_cready, e_wv;
        logic [2:0]  e_wsel;
        logic [63:0] e_wdata;
        logic [7:0]  e_pend;
    } vec_t;

    vec_t vecs[$];

    function void add(input logic rst, iv, iw, input logic [2:0] idst, input logic [7:0] isrc,
                      input logic [63:0] idata, input logic dv, input logic [2:0] ddst,
                      input logic [63:0] ddata, input logic cv, input logic [2:0] cdst,
                      input logic [63:0] cdata, input logic e_stall, e_dready, e_cready, e_wv,
                      input logic [2:0] e_wsel, input logic [63:0] e_wdata, input logic [7:0] e_pend);
        vec_t v;
        v.rst = rst; v.iv = iv; v.iw = iw; v.idst = idst; v.isrc = isrc; v.idata = idata;
        v.dv = dv; v.ddst = ddst; v.ddata = ddata; v.cv = cv; v.cdst = cdst; v.cdata = cdata;
        v.e_stall = e_stall; v.e_dready = e_dready; v.e_cready = e_cready; v.e_wv = e_wv;
        v.e_wsel = e_wsel; v.e_wdata = e_wdata; v.e_pend = e_pend;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        reset               = v.rst;
        bus.inst_v_i        = v.iv;
        bus.inst_w_v_i      = v.iw;
        bus.inst_dst_i      = v.idst;
        bus.inst_src_mask_i = v.isrc;
        bus.inst_data_i     = v.idata;
        bus.dir_v_i         = v.dv;
        bus.dir_dst_i       = v.ddst;
        bus.dir_data_i      = v.ddata;
        bus.cfg_v_i         = v.cv;
        bus.cfg_dst_i       = v.cdst;
        bus.cfg_data_i      = v.cdata;
    endtask

    // Scoreboard counters may never exceed FIFO depth (an underflow wraps above it too).
    always @(negedge clk) begin
        if (started && !reset) begin
            for (int i = 0; i < NG; i++) begin
                if (int'(dut.cnt_q[i]) > DEPTH) begin
                    bad++;
                    $display("FAIL cnt_range gpr%0d cnt=%0d max=%0d", i, dut.cnt_q[i], DEPTH);
                end
            end
        end
    end

    initial begin
        vec_t idle;
        int   lat;
        bit   seen;

        // rst iv iw idst isrc idata | dv ddst ddata | cv cdst cdata || stall drdy crdy wv wsel wdata pend
        add(1,1,1,0,8'h00,64'hD0, 0,0,64'h0,    1,6,64'h66, 0,1,0,0,0,64'h0,   8'h00); // 0 in reset
        add(0,1,0,0,8'h08,64'h0,  1,3,64'hA5,   0,0,64'h0,  0,1,0,0,0,64'h0,   8'h00); // 1 enq GPR3
        add(0,1,0,0,8'h08,64'h0,  0,0,64'h0,    0,0,64'h0,  1,1,0,1,3,64'hA5,  8'h08); // 2 hazard + write
        add(0,1,0,0,8'h08,64'h0,  0,0,64'h0,    0,0,64'h0,  0,1,0,0,0,64'h0,   8'h00); // 3 stall drops
        for (int k = 0; k < 4; k++)
            add(0,1,1,0,8'h00,64'hD0, 0,0,64'h0, 1,6,64'h66, 0,1,0,1,0,64'hD0, 8'h00); // 4..7 inst wins
        add(0,1,1,0,8'h00,64'hD0, 0,0,64'h0,    1,6,64'h66, 1,1,1,1,6,64'h66,  8'h00); // 8 starve override
        for (int k = 0; k < 3; k++)
            add(0,1,1,0,8'h00,64'hD0, 0,0,64'h0, 1,6,64'h66, 0,1,0,1,0,64'hD0, 8'h00); // 9..11 counter restarted
        add(0,1,1,0,8'h00,64'hD0, 1,1,64'h11,   1,6,64'h66, 0,1,0,1,0,64'hD0,  8'h00); // 12 enq GPR1
        add(0,1,1,0,8'h00,64'hD0, 1,2,64'h22,   1,6,64'h66, 1,1,1,1,6,64'h66,  8'h02); // 13 override, fill
        add(0,1,1,0,8'h00,64'hD0, 1,4,64'h44,   1,6,64'h66, 1,0,0,1,1,64'h11,  8'h06); // 14 full, deq GPR1
        add(0,1,1,0,8'h00,64'hD0, 1,4,64'h44,   1,6,64'h66, 1,1,0,1,2,64'h22,  8'h04); // 15 enq+deq, wrap
        add(0,1,1,0,8'h00,64'hD0, 0,0,64'h0,    1,6,64'h66, 1,1,0,1,4,64'h44,  8'h10); // 16 deq GPR4
        add(0,1,1,0,8'h00,64'hD0, 0,0,64'h0,    0,0,64'h0,  0,1,0,1,0,64'hD0,  8'h00); // 17 cfg drop
        for (int k = 0; k < 3; k++)
            add(0,1,1,0,8'h00,64'hD0, 0,0,64'h0, 1,6,64'h66, 0,1,0,1,0,64'hD0, 8'h00); // 18..20
        add(0,1,1,0,8'h00,64'hD0, 1,5,64'h51,   1,6,64'h66, 0,1,0,1,0,64'hD0,  8'h00); // 21 enq GPR5
        add(0,1,1,0,8'h00,64'hD0, 1,5,64'h52,   1,6,64'h66, 1,1,1,1,6,64'h66,  8'h20); // 22 second GPR5
        add(0,1,1,0,8'h00,64'hD0, 1,5,64'h53,   0,0,64'h0,  1,0,0,1,5,64'h51,  8'h20); // 23 full, deq
        add(0,1,1,5,8'h00,64'hD5, 1,5,64'h53,   0,0,64'h0,  1,1,0,1,5,64'h52,  8'h20); // 24 enq+deq same GPR
        add(0,1,0,0,8'h01,64'h0,  0,0,64'h0,    0,0,64'h0,  0,1,0,1,5,64'h53,  8'h20); // 25 reader no hazard
        add(0,1,1,5,8'h00,64'hD5, 0,0,64'h0,    0,0,64'h0,  0,1,0,1,5,64'hD5,  8'h00); // 26 GPR5 free
        for (int k = 0; k < 3; k++)
            add(0,1,1,0,8'h00,64'hD0, 0,0,64'h0, 1,6,64'h66, 0,1,0,1,0,64'hD0, 8'h00); // 27..29
        add(0,1,1,0,8'h00,64'hD0, 1,6,64'h61,   1,6,64'h66, 0,1,0,1,0,64'hD0,  8'h00); // 30 enq GPR6
        add(0,1,1,0,8'h00,64'hD0, 1,6,64'h62,   1,6,64'h66, 1,1,1,1,6,64'h66,  8'h40); // 31 full, cnt6=2
        add(1,1,1,0,8'h00,64'hD0, 1,6,64'h63,   1,6,64'h66, 0,0,0,0,0,64'h0,   8'h00); // 32 reset w/ entries
        add(0,0,0,0,8'h00,64'h0,  0,0,64'h0,    0,0,64'h0,  0,1,0,0,0,64'h0,   8'h00); // 33 no stale write
        add(0,0,0,0,8'h00,64'h0,  0,0,64'h0,    0,0,64'h0,  0,1,0,0,0,64'h0,   8'h00); // 34
`ifdef BP_CCE_GPR_WR_SCHED_BYPASS_EN
        add(0,0,0,0,8'h00,64'h0,  1,7,64'h1234, 0,0,64'h0,  0,1,0,1,7,64'h1234,8'h00); // 35 bypass
        add(0,0,0,0,8'h00,64'h0,  0,0,64'h0,    0,0,64'h0,  0,1,0,0,0,64'h0,   8'h00); // 36
`else
        add(0,0,0,0,8'h00,64'h0,  1,7,64'h1234, 0,0,64'h0,  0,1,0,0,0,64'h0,   8'h00); // 35 enq GPR7
        add(0,0,0,0,8'h00,64'h0,  0,0,64'h0,    0,0,64'h0,  0,1,0,1,7,64'h1234,8'h80); // 36 one cycle later
`endif

        idle = vecs[vecs.size()-1];
        idle.dv = 0;
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        started = 1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            @(negedge clk);
            total++;
            if (bus.stall_o !== vecs[k].e_stall || bus.dir_ready_o !== vecs[k].e_dready ||
                bus.cfg_ready_o !== vecs[k].e_cready || bus.gpr_w_v_o !== vecs[k].e_wv ||
                bus.pending_o !== vecs[k].e_pend ||
                (vecs[k].e_wv && (bus.gpr_w_sel_o !== vecs[k].e_wsel || bus.gpr_w_data_o !== vecs[k].e_wdata))) begin
                bad++;
                $display("FAIL vec%0d got stall=%b drdy=%b crdy=%b wv=%b sel=%0d data=%h pend=%h want stall=%b drdy=%b crdy=%b wv=%b sel=%0d data=%h pend=%h",
                         k, bus.stall_o, bus.dir_ready_o, bus.cfg_ready_o, bus.gpr_w_v_o, bus.gpr_w_sel_o,
                         bus.gpr_w_data_o, bus.pending_o, vecs[k].e_stall, vecs[k].e_dready, vecs[k].e_cready,
                         vecs[k].e_wv, vecs[k].e_wsel, vecs[k].e_wdata, vecs[k].e_pend);
            end
            @(posedge clk);
            #1;
        end

        // Directory write latency, bounded wait for the write port to carry it.
        drive(idle);
        bus.dir_v_i    = 1'b1;
        bus.dir_dst_i  = 3'd2;
        bus.dir_data_i = 64'hBEEF;
        lat  = 0;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (bus.gpr_w_v_o && bus.gpr_w_sel_o == 3'd2) begin
                seen = 1;
                lat  = c;
                total++;
                if (bus.gpr_w_data_o !== 64'hBEEF) begin
                    bad++;
                    $display("FAIL dir_data got=%h want=%h", bus.gpr_w_data_o, 64'hBEEF);
                end
            end
            @(posedge clk);
            #1;
            bus.dir_v_i = 1'b0;
        end
        total++;
`ifdef BP_CCE_GPR_WR_SCHED_BYPASS_EN
        if (!seen || lat != 0) begin
            bad++;
            $display("FAIL dir_latency seen=%0d got=%0d want=0", seen, lat);
        end
`else
        if (!seen || lat != 1) begin
            bad++;
            $display("FAIL dir_latency seen=%0d got=%0d want=1", seen, lat);
        end
`endif

        @(negedge clk);
        total++;
        if (bus.pending_o !== 8'h00 || bus.gpr_w_v_o !== 1'b0) begin
            bad++;
            $display("FAIL drain got pend=%h wv=%b want pend=00 wv=0", bus.pending_o, bus.gpr_w_v_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
